fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Instruction-fetch stage for the 8-bit core. It owns the program counter and drives it to the instruction memory as pc_out. It captures the returned 8-bit instruction into an IF/ID register with its PC and a valid bit, which feeds the decoder. It also handles stall, branch/jump redirect, halt/resume, and a saturating fetch counter.

Parameters:
PC_W, 8, program counter width.
PC_LAST, 4, highest legal instruction address; sequential PC wraps from PC_LAST to 0.
CNT_W, 16, width of the fetched-instruction counter.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  asynchronous, active-high reset.
stall  in  1  hold PC and IF/ID contents this cycle.
redirect_valid  in  1  branch/jump taken this cycle.
redirect_pc  in  PC_W  redirect target.
halt_req  in  1  request to stop fetching.
resume  in  1  restart fetching from the held PC.
instr_in  in  8  instruction returned by instruction memory for pc_out (combinational, same cycle).
pc_out  out  PC_W  current PC presented to instruction memory.
ifid_instr  out  8  latched instruction.
ifid_pc  out  PC_W  PC of latched instruction.
ifid_valid  out  1  ifid_instr is a real instruction, not a bubble.
halted  out  1  FSM is in HALTED.
redirect_err  out  1  sticky flag: a redirect target exceeded PC_LAST.
fetch_count  out  CNT_W  number of instructions delivered with valid=1; saturates.

Behaviour:
- Reset (async, any time, including mid-stall or mid-halt): pc=0, ifid_instr=8'h00, ifid_pc=0, ifid_valid=0, halted=0, redirect_err=0, fetch_count=0, FSM=BOOT.
- FSM states: BOOT, RUN, HALTED.
  - BOOT: one bubble cycle (ifid_valid=0, pc held at 0). Always goes to RUN next cycle. Inputs are ignored.
  - RUN, normal case (no stall, no redirect, no halt): ifid_instr<=instr_in, ifid_pc<=pc, ifid_valid<=1, pc<=(pc==PC_LAST)?0:pc+1, fetch_count++ (held at all-ones once reached).
  - RUN, redirect_valid=1: highest priority, overrides stall and halt_req.
    - pc<=redirect_pc if redirect_pc<=PC_LAST; otherwise pc<=0 and redirect_err<=1.
    - ifid_instr<=8'h00, ifid_valid<=0 (wrong-path flush).
    - ifid_pc is updated as in the normal case.
    - fetch_count does not increment.
  - RUN, stall=1 (no redirect): pc, ifid_*, fetch_count all hold. halt_req is still sampled.
  - RUN, halt_req=1 (no redirect): go to HALTED.
    - If not stalled, the instruction at the current pc is latched as in the normal case and pc advances.
    - If stalled, everything holds.
  - HALTED: halted=1. pc, ifid_instr and ifid_pc hold. ifid_valid<=0.
    - resume=1 goes to RUN; fetching restarts from the held pc on the next cycle.
    - redirect_valid in HALTED loads pc per the rules above and stays HALTED.
    - stall is ignored.
- pc_out = pc (combinational from register). Latency PC→IF/ID is 1 cycle.
- Arithmetic: pc+1 is PC_W-bit. No modulo operators; wrap is the explicit compare against PC_LAST. redirect_err is cleared only by reset.
- halt_req and resume both high in HALTED: resume wins. Both high in RUN: halt wins.

Decomposition:
- Shared package core_pkg: PC_W, NOP_INSTR=8'h00, the fetch FSM state enum {BOOT, RUN, HALTED}, and the opcode constants used by the decoder.
- One sub-module: fetch_next_pc. Combinational next-PC select covering wrap, redirect, range check and the error pulse. The FSM, IF/ID register and counter stay in fetch_unit.

Test Plan:
- Reset then free-run with memory image {D2,11,72,B2,E5}. Required response:
  - Cycle 1 is a bubble.
  - Then ifid_instr = D2,11,72,B2,E5,D2 with ifid_pc = 0,1,2,3,4,0.
  - fetch_count=6.
- stall high 3 cycles while pc=2: pc_out stays 2, ifid stays (11,pc1,valid 1), fetch_count frozen. On release, 72 is latched next.
- redirect_valid with redirect_pc=1 while pc=3, stall also high: next cycle ifid_valid=0, ifid_instr=00, pc=1. The cycle after, ifid_instr=11.
- redirect_pc=7 (>PC_LAST): pc=0, redirect_err=1 and stays 1 through 10 further cycles.
- halt_req at pc=2, then resume 4 cycles later: halted=1 for those cycles, ifid_valid=0, pc holds 3. After resume, ifid_instr=B2 with ifid_pc=3.
- Assert reset mid-HALTED with pc=3, fetch_count=5: all outputs return to their reset values immediately, without waiting for a clock edge. The BOOT bubble is repeated.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the 8-bit core: widths, fetch FSM states and the
// opcode map that the decoder consumes.
package core_pkg;
  localparam int PC_W    = 8;
  localparam int PC_LAST = 4;
  localparam int CNT_W   = 16;

  localparam logic [7:0] NOP_INSTR = 8'h00;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  // Upper nibble of an instruction selects the operation.
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h7;
  localparam logic [3:0] OP_LD  = 4'hB;
  localparam logic [3:0] OP_ST  = 4'hD;
  localparam logic [3:0] OP_JMP = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;
endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC select: sequential advance with explicit wrap at PC_LAST, or a
// range-checked redirect that falls back to 0 and raises an error pulse.
module fetch_next_pc #(
  parameter int PC_W    = core_pkg::PC_W,
  parameter int PC_LAST = core_pkg::PC_LAST
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic            advance_i,
  input  logic            redirect_i,
  input  logic [PC_W-1:0] redirect_pc_i,
  output logic [PC_W-1:0] next_pc_o,
  output logic            err_o
);
  localparam logic [PC_W-1:0] LAST_PC = PC_W'(PC_LAST);

  logic [PC_W-1:0] seq_pc;

  assign seq_pc = (pc_i == LAST_PC) ? '0 : pc_i + PC_W'(1);

  always_comb begin
    next_pc_o = pc_i;
    err_o     = 1'b0;
    if (redirect_i) begin
      if (redirect_pc_i <= LAST_PC) begin
        next_pc_o = redirect_pc_i;
      end else begin
        next_pc_o = '0;
        err_o     = 1'b1;
      end
    end else if (advance_i) begin
      next_pc_o = seq_pc;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fills the IF/ID register and runs the
// BOOT/RUN/HALTED control FSM plus a saturating delivered-instruction counter.
module fetch_unit
  import core_pkg::*;
#(
  parameter int PC_W    = core_pkg::PC_W,
  parameter int PC_LAST = core_pkg::PC_LAST,
  parameter int CNT_W   = core_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [PC_W-1:0]  redirect_pc,
  input  logic             halt_req,
  input  logic             resume,
  input  logic [7:0]       instr_in,
  output logic [PC_W-1:0]  pc_out,
  output logic [7:0]       ifid_instr,
  output logic [PC_W-1:0]  ifid_pc,
  output logic             ifid_valid,
  output logic             halted,
  output logic             redirect_err,
  output logic [CNT_W-1:0] fetch_count,
  output logic [1:0]       fsm_state
);
  fetch_state_e     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [7:0]       instr_q, instr_d;
  logic [PC_W-1:0]  ifpc_q, ifpc_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic redirect_en, advance, err_pulse;

  // BOOT ignores every input, so redirects only take effect once running.
  assign redirect_en = redirect_valid && (state_q != BOOT);
  assign advance     = (state_q == RUN) && !stall && !redirect_valid;

  fetch_next_pc #(
    .PC_W    (PC_W),
    .PC_LAST (PC_LAST)
  ) u_next_pc (
    .pc_i          (pc_q),
    .advance_i     (advance),
    .redirect_i    (redirect_en),
    .redirect_pc_i (redirect_pc),
    .next_pc_o     (pc_d),
    .err_o         (err_pulse)
  );

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    err_d   = err_q | err_pulse;
    case (state_q)
      BOOT: begin
        state_d = RUN;
        valid_d = 1'b0;
      end
      RUN: begin
        if (redirect_valid) begin
          instr_d = NOP_INSTR;
          ifpc_d  = pc_q;
          valid_d = 1'b0;
        end else begin
          if (!stall) begin
            instr_d = instr_in;
            ifpc_d  = pc_q;
            valid_d = 1'b1;
            if (~&cnt_q) cnt_d = cnt_q + CNT_W'(1);
          end
          if (halt_req) state_d = HALTED;
        end
      end
      HALTED: begin
        valid_d = 1'b0;
        if (resume) state_d = RUN;
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      ifpc_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_out       = pc_q;
  assign ifid_instr   = instr_q;
  assign ifid_pc      = ifpc_q;
  assign ifid_valid   = valid_q;
  assign halted       = (state_q == HALTED);
  assign redirect_err = err_q;
  assign fetch_count  = cnt_q;
  assign fsm_state    = state_q;
endmodule
